// File: rtl/acc_pkg.sv
// Shared definitions for the accumulator back-end stages: default widths,
// the derived block-sum width and the block averager state encoding.
package acc_pkg;

    // Default sample width, which is the accumulator's c width
    localparam int DEF_DATA_W = 8;

    // Default log2 of the block length (4 samples per block)
    localparam int DEF_LOG2_N = 2;

    // Width of an exact block sum; N samples of DATA_W bits cannot overflow it
    localparam int SUM_W = DEF_DATA_W + DEF_LOG2_N;

    // ACCUM collects samples, HOLD presents a finished block until it is taken
    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } avg_state_t;

endpackage : acc_pkg

// File: rtl/acc_block_averager.sv
// Block averager: sums blocks of 2**LOG2_N unsigned samples and presents the
// exact sum plus the floor average on a valid/ready output. While a result
// waits in HOLD, input acceptance follows out_ready, so the hand-off of a result
// and the first sample of the next block can share one cycle.
module acc_block_averager
    import acc_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int LOG2_N = DEF_LOG2_N
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     in_valid,
    input  logic [DATA_W-1:0]        in_data,
    output logic                     in_ready,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W+LOG2_N-1:0] out_sum,
    output logic [DATA_W-1:0]        out_data
);

    localparam int BLK_W = DATA_W + LOG2_N;

    // Count value of the last sample of a block (N-1) and the count after the first one
    localparam logic [LOG2_N-1:0] CNT_LAST = '1;
    localparam logic [LOG2_N-1:0] CNT_ONE  = LOG2_N'(1);

    avg_state_t        state;
    avg_state_t        state_next;
    logic [BLK_W-1:0]  sum;
    logic [BLK_W-1:0]  sum_next;
    logic [LOG2_N-1:0] cnt;
    logic [LOG2_N-1:0] cnt_next;
    logic [BLK_W-1:0]  sum_acc;
    logic              load_out;
    logic              take_in;
    logic              take_out;

    // A result is being presented exactly while the FSM sits in HOLD
    assign out_valid = (state == HOLD);

    // Input is blocked in reset and under clr; in HOLD it is accepted only when the result leaves
    assign in_ready = rst_n && !clr && ((state == ACCUM) || out_ready);

    assign take_in  = in_valid && in_ready;
    assign take_out = out_valid && out_ready;

    // Running sum including the sample offered this cycle
    assign sum_acc = sum + BLK_W'(in_data);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ACCUM;
        end else begin
            state <= state_next;
        end
    end

    // Next-state, accumulation and result-load decisions
    always_comb begin
        state_next = state;
        sum_next   = sum;
        cnt_next   = cnt;
        load_out   = 1'b0;
        case (state)
            ACCUM: begin
                if (clr) begin
                    sum_next = '0;
                    cnt_next = '0;
                end else if (take_in) begin
                    if (cnt == CNT_LAST) begin
                        load_out   = 1'b1;
                        sum_next   = '0;
                        cnt_next   = '0;
                        state_next = HOLD;
                    end else begin
                        sum_next = sum_acc;
                        cnt_next = cnt + CNT_ONE;
                    end
                end
            end
            HOLD: begin
                if (clr) begin
                    sum_next = '0;
                    cnt_next = '0;
                end
                if (take_out) begin
                    state_next = ACCUM;
                end
                if (take_in) begin
                    sum_next = BLK_W'(in_data);
                    cnt_next = CNT_ONE;
                end
            end
            default: begin
                state_next = ACCUM;
                sum_next   = '0;
                cnt_next   = '0;
            end
        endcase
    end

    // Partial-block sum and sample count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum <= '0;
            cnt <= '0;
        end else begin
            sum <= sum_next;
            cnt <= cnt_next;
        end
    end

    // Result registers change only when a block completes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_sum  <= '0;
            out_data <= '0;
        end else if (load_out) begin
            out_sum  <= sum_acc;
            out_data <= sum_acc[BLK_W-1:LOG2_N];
        end
    end

endmodule : acc_block_averager

// File: tb/tb_acc_block_averager.sv
// Scoreboard bench for acc_block_averager: an input-side model pushes each
// expected block sum when its fourth sample is accepted, and an output monitor
// pops and compares whenever a result is handed off.
module tb_acc_block_averager;

    logic       clk;
    logic       rst_n;
    logic       clr;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic       out_ready;
    logic [9:0] out_sum;
    logic [7:0] out_data;

    int total;
    int bad;
    int popped;
    int m_sum;
    int m_cnt;
    int sb[$];
    bit rand_phase;

    acc_block_averager #(.DATA_W(8), .LOG2_N(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_data  (out_data)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    // Offer one sample and hold it until it is accepted; entered and left just after a rising edge
    task automatic applyStimulus(input logic [7:0] d);
        int waited;
        waited   = 0;
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
        while (!in_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            checkOutput("input_accept_timeout", 32'(in_ready), 32'd1);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Reference model of accepted samples; produces one expected sum per block of four
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_sum = 0;
            m_cnt = 0;
            sb.delete();
        end else if (clr) begin
            m_sum = 0;
            m_cnt = 0;
        end else if (in_valid && in_ready) begin
            m_sum = m_sum + int'(in_data);
            m_cnt++;
            if (m_cnt == 4) begin
                sb.push_back(m_sum);
                m_sum = 0;
                m_cnt = 0;
            end
        end
    end

    // Output monitor: every handed-off result must match the oldest expected block
    always @(negedge clk) begin
        int exp_sum;
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_result", 32'(out_sum), 32'hFFFF_FFFF);
            end else begin
                exp_sum = sb.pop_front();
                popped++;
                checkOutput("out_sum", 32'(out_sum), 32'(exp_sum));
                checkOutput("out_data", 32'(out_data), 32'(exp_sum >> 2));
            end
        end
    end

    // Directed scenarios followed by a randomized handshake run
    initial begin
        int n;
        total = 0; bad = 0; popped = 0;
        rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        rand_phase = 1'b0;

        #3;
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_out_sum", 32'(out_sum), 32'd0);
        checkOutput("reset_out_data", 32'(out_data), 32'd0);
        checkOutput("reset_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        $display("[TB] block of 16s");
        out_ready = 1'b1;
        repeat (4) applyStimulus(8'd16);
        checkOutput("latency_out_valid", 32'(out_valid), 32'd1);
        @(posedge clk); #1;
        checkOutput("single_cycle_out_valid", 32'(out_valid), 32'd0);

        $display("[TB] floor average and full-scale block");
        applyStimulus(8'd1); applyStimulus(8'd2); applyStimulus(8'd3); applyStimulus(8'd4);
        repeat (4) applyStimulus(8'd255);
        @(posedge clk); #1;

        $display("[TB] backpressure in HOLD");
        out_ready = 1'b0;
        repeat (4) applyStimulus(8'd5);
        in_valid = 1'b1;
        in_data  = 8'd7;
        repeat (5) begin
            @(negedge clk);
            checkOutput("hold_in_ready", 32'(in_ready), 32'd0);
            checkOutput("hold_out_valid", 32'(out_valid), 32'd1);
            checkOutput("hold_out_sum", 32'(out_sum), 32'd20);
            checkOutput("hold_out_data", 32'(out_data), 32'd5);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        applyStimulus(8'd7);
        checkOutput("handoff_out_valid", 32'(out_valid), 32'd0);
        applyStimulus(8'd1); applyStimulus(8'd1); applyStimulus(8'd1);
        @(posedge clk); #1;

        $display("[TB] clr flush");
        applyStimulus(8'd7); applyStimulus(8'd9);
        clr = 1'b1; in_valid = 1'b1; in_data = 8'd50;
        @(negedge clk);
        checkOutput("clr_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        clr = 1'b0; in_valid = 1'b0;
        repeat (4) applyStimulus(8'd3);
        @(posedge clk); #1;

        $display("[TB] asynchronous reset mid-block and in HOLD");
        repeat (3) applyStimulus(8'd10);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midblock_rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("midblock_rst_out_sum", 32'(out_sum), 32'd0);
        checkOutput("midblock_rst_out_data", 32'(out_data), 32'd0);
        checkOutput("midblock_rst_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b0;
        repeat (4) applyStimulus(8'd9);
        checkOutput("pre_rst_hold_out_sum", 32'(out_sum), 32'd36);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("hold_rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("hold_rst_out_sum", 32'(out_sum), 32'd0);
        checkOutput("hold_rst_out_data", 32'(out_data), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (4) applyStimulus(8'd20);
        @(posedge clk); #1;

        $display("[TB] random gaps over 1000 samples");
        rand_phase = 1'b1;
        fork
            begin
                while (rand_phase) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join_none
        for (int i = 0; i < 1000; i++) begin
            n = $urandom_range(0, 2);
            repeat (n) begin
                @(posedge clk); #1;
            end
            applyStimulus(8'($urandom_range(0, 255)));
        end
        rand_phase = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        out_ready = 1'b1;
        n = 0;
        while ((sb.size() != 0 || out_valid) && n < 50) begin
            @(posedge clk);
            n++;
        end
        #2;
        checkOutput("drain_pending", 32'(sb.size()), 32'd0);
        checkOutput("blocks_delivered", 32'(popped), 32'd257);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_acc_block_averager
